demux4_5_fifo: RTL and testbench

Routing block for 5-bit register-index traffic, the distribution counterpart of the 4:1 5-bit selector on the datapath. Accepts one `WIDTH`-bit word per cycle tagged with a 2-bit channel select and delivers it to one of four output channels. Each channel has its own small FIFO and valid/ready handshake, so a stalled consumer never blocks the other three. Sits between the control unit's destination-index generator and the four downstream consumers (write-back port, forwarding unit, hazard unit, debug tap).

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux4_5_fifo_fila_canal.sv | 58 +++++
 rtl/demux4_5_fifo.sv | 66 ++++++
 tb/tb_demux4_5_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 4-way register-index demux.
// Channel count, select width and the default word width.
package demux_pkg;

  localparam int CANAIS    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 5;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [CANAIS-1:0] sel_onehot(input sel_t s);
    logic [CANAIS-1:0] oh;
    oh = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux4_5_fifo_fila_canal.sv
// Single-channel synchronous FIFO; occupancy is tracked apart
// from the pointers so full and empty never alias.
module fila_canal #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux4_5_fifo.sv
// Routes one tagged word per cycle into one of four
// independently handshaked channel FIFOs.
module demux4_5_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  sel_t                sel,
  input  logic [WIDTH-1:0]    E,
  input  logic                e_valid,
  output logic                e_ready,
  output logic [WIDTH-1:0]    S0,
  output logic [WIDTH-1:0]    S1,
  output logic [WIDTH-1:0]    S2,
  output logic [WIDTH-1:0]    S3,
  output logic [CANAIS-1:0]   s_valid,
  input  logic [CANAIS-1:0]   s_ready,
  output logic [CANAIS*CW-1:0] count
);

  logic [CANAIS-1:0] push_en;
  logic [CANAIS-1:0] pop_en;
  logic [CANAIS-1:0] full;
  logic [CANAIS-1:0] empty;
  logic [WIDTH-1:0]  head [CANAIS];
  logic [WIDTH-1:0]  masked [CANAIS];
  logic [CW-1:0]     cnt [CANAIS];
  logic              accept;

  // Ready depends only on sel and stored state, never on s_ready.
  assign e_ready = ~full[sel];
  assign accept  = e_valid & e_ready;
  assign push_en = accept ? sel_onehot(sel) : '0;
  assign pop_en  = s_valid & s_ready;

  for (genvar n = 0; n < CANAIS; n++) begin : g_ch
    fila_canal #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fila (
      .clk   (clk),
      .reset (reset),
      .push  (push_en[n]),
      .pop   (pop_en[n]),
      .din   (E),
      .dout  (head[n]),
      .count (cnt[n]),
      .full  (full[n]),
      .empty (empty[n])
    );

    assign s_valid[n]           = ~empty[n];
    assign masked[n]            = s_valid[n] ? head[n] : '0;
    assign count[n*CW +: CW]    = cnt[n];
  end

  assign S0 = masked[0];
  assign S1 = masked[1];
  assign S2 = masked[2];
  assign S3 = masked[3];

endmodule

// File: tb/tb_demux4_5_fifo.sv
// Directed checks plus a queue-model soak for the channel demux.
// Every expected value comes from constants or the per-channel queues.
module tb_demux4_5_fifo;

  localparam int W  = 5;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    sel;
  logic [W-1:0]  E;
  logic          e_valid;
  logic          e_ready;
  logic [W-1:0]  S0, S1, S2, S3;
  logic [3:0]    s_valid;
  logic [3:0]    s_ready;
  logic [4*CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q [4][$];

  demux4_5_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .E       (E),
    .e_valid (e_valid),
    .e_ready (e_ready),
    .S0      (S0),
    .S1      (S1),
    .S2      (S2),
    .S3      (S3),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int n);
    return 32'(count[n*CW +: CW]);
  endfunction

  function automatic logic [31:0] s_of(input int n);
    case (n)
      0:       return 32'(S0);
      1:       return 32'(S1);
      2:       return 32'(S2);
      default: return 32'(S3);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_svalid"}, 32'(s_valid), 32'h0);
    for (int n = 0; n < 4; n++) begin
      check($sformatf("%s_S%0d", tag, n), s_of(n), 32'h0);
      check($sformatf("%s_cnt%0d", tag, n), cnt_of(n), 32'h0);
      sel = 2'(n);
      #1;
      check($sformatf("%s_rdy%0d", tag, n), 32'(e_ready), 32'h1);
    end
  endtask

  task automatic push1(input logic [1:0] s, input logic [W-1:0] v);
    sel = s;
    E = v;
    e_valid = 1'b1;
    tick();
    e_valid = 1'b0;
  endtask

  task automatic soak(input int cycles, input bit stall0);
    logic [3:0] rdy;
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      sel     = 2'($urandom_range(0, 3));
      E       = W'($urandom);
      e_valid = 1'($urandom);
      rdy     = 4'($urandom);
      if (stall0) rdy[0] = 1'b0;
      s_ready = rdy;
      #1;
      for (int n = 0; n < 4; n++) begin
        check($sformatf("soak_v%0d", n), 32'(s_valid[n]),
              32'(q[n].size() != 0));
        check($sformatf("soak_S%0d", n), s_of(n),
              q[n].size() != 0 ? 32'(q[n][0]) : 32'h0);
        check($sformatf("soak_cnt%0d", n), cnt_of(n), 32'(q[n].size()));
      end
      check("soak_rdy", 32'(e_ready), 32'(q[sel].size() < D));
      acc = e_valid && (q[sel].size() < D);
      for (int n = 0; n < 4; n++) begin
        if (rdy[n] && q[n].size() != 0) void'(q[n].pop_front());
      end
      if (acc) q[sel].push_back(E);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    sel = '0;
    E = '0;
    e_valid = 1'b0;
    s_ready = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle("reset");

    push1(2'd2, 5'h13);
    check("route_S2", 32'(S2), 32'h13);
    check("route_sv", 32'(s_valid), 32'h4);
    check("route_cnt2", cnt_of(2), 32'h1);
    check("route_S0", 32'(S0), 32'h0);
    check("route_S1", 32'(S1), 32'h0);
    check("route_S3", 32'(S3), 32'h0);

    push1(2'd1, 5'h01);
    push1(2'd1, 5'h02);
    sel = 2'd1;
    #1;
    check("full_rdy1", 32'(e_ready), 32'h0);
    sel = 2'd0;
    #1;
    check("full_rdy0", 32'(e_ready), 32'h1);
    push1(2'd1, 5'h03);
    check("refuse_cnt1", cnt_of(1), 32'h2);
    check("refuse_S1", 32'(S1), 32'h01);
    sel = 2'd1;
    s_ready = 4'b0010;
    #1;
    check("pop_rdy_before", 32'(e_ready), 32'h0);
    tick();
    s_ready = '0;
    check("pop_S1", 32'(S1), 32'h02);
    check("pop_rdy_after", 32'(e_ready), 32'h1);
    check("pop_cnt1", cnt_of(1), 32'h1);

    push1(2'd3, 5'h0A);
    s_ready = 4'b1000;
    push1(2'd3, 5'h0B);
    s_ready = '0;
    check("pp_cnt3", cnt_of(3), 32'h1);
    check("pp_S3", 32'(S3), 32'h0B);

    push1(2'd2, 5'h14);
    check("pre_rst_cnt2", cnt_of(2), 32'h2);
    check("pre_rst_S2", 32'(S2), 32'h13);
    reset = 1'b1;
    #1;
    check_idle("midrst");
    reset = 1'b0;
    tick();

    soak(3000, 1'b1);
    soak(2000, 1'b0);
    e_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_ready = 4'hF;
      tick();
    end
    s_ready = '0;
    check("drain_sv", 32'(s_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
